// File: rtl/vga_frame_loader.sv
// vga_frame_loader: streams one frame of 8-bit pixels from a granted source
// memory to a VGA driver, converting to 12-bit {R4,G4,B4} on the way.
module vga_frame_loader #(
  parameter int NUM_PIX = 131072,
  parameter int ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              mode,
  input  logic              abort,
  input  logic              mem_gnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              start,
  output logic              we,
  output logic [11:0]       wdata,
  output logic              done,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] cnt;
  logic              mode_q;
  logic              last_rd;

  // Reads only happen in RUN, and only when the memory grants this cycle.
  assign rd_en   = (state == RUN) && mem_gnt;
  assign rd_addr = cnt;
  assign start   = (state == START);
  assign done    = (state == DONE);
  assign busy    = (state != IDLE);
  assign last_rd = rd_en && (cnt == LAST);

  // Next-state logic; abort only matters while a transfer is in flight.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (go) nxt = START;
      START:   nxt = abort ? IDLE : RUN;
      RUN:     if (abort) nxt = IDLE;
               else if (last_rd) nxt = DRAIN;
      DRAIN:   nxt = abort ? IDLE : DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Read counter: advances per issued read, cleared outside RUN or on abort,
  // so it never passes NUM_PIX-1 and every frame starts from address 0.
  always_ff @(posedge clk) begin
    if (rst || abort || state != RUN) cnt <= '0;
    else if (rd_en)                   cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  // Pixel format is captured only when a frame request is accepted.
  always_ff @(posedge clk) begin
    if (rst)                      mode_q <= 1'b0;
    else if (state == IDLE && go) mode_q <= mode;
  end

  // Write strobe trails the read by one cycle, lining up with rd_data;
  // an aborted read never produces a write.
  always_ff @(posedge clk) begin
    if (rst) we <= 1'b0;
    else     we <= rd_en && !abort;
  end

  // Pixel conversion; held at zero whenever no write is presented.
  always_comb begin
    wdata = '0;
    if (we) begin
      if (mode_q)
        wdata = {rd_data[7:5], rd_data[7], rd_data[4:2], rd_data[4],
                 rd_data[1:0], rd_data[1:0]};
      else
        wdata = {rd_data[7:4], rd_data[7:4], rd_data[7:4]};
    end
  end

endmodule

// File: tb/tb_vga_frame_loader.sv
// tb_vga_frame_loader: directed per-cycle vectors plus a stalled-grant frame.
module tb_vga_frame_loader;
  localparam int NUM_PIX = 4;
  localparam int ADDR_W  = 2;

  logic              clk = 1'b0;
  logic              rst, go, mode, abort, mem_gnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              start, we, done, busy;
  logic [11:0]       wdata;

  int checks = 0;
  int errors = 0;

  vga_frame_loader #(.NUM_PIX(NUM_PIX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .go(go), .mode(mode), .abort(abort),
    .mem_gnt(mem_gnt), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .start(start), .we(we), .wdata(wdata), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, g, m, a, n;
    logic [7:0]  d;
    logic        s, b, e;
    logic [1:0]  ad;
    logic        w;
    logic [11:0] wd;
    logic        dn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, g, m, a, n, input logic [7:0] d,
                     input logic s, b, e, input logic [1:0] ad,
                     input logic w, input logic [11:0] wd, input logic dn);
    vec_t v;
    v.r = r; v.g = g; v.m = m; v.a = a; v.n = n; v.d = d;
    v.s = s; v.b = b; v.e = e; v.ad = ad; v.w = w; v.wd = wd; v.dn = dn;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic [7:0]  smem [4];
  logic [11:0] sexp [4];

  initial begin
    //   r  g  m  a  n  d        s  b  e  ad w  wd      dn
    // reset state
    add(1, 0, 0, 0, 0, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    // A: full grayscale frame, grant always high
    add(0, 1, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   1, 1, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 1, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 1, 1, 1, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h5F,   0, 1, 1, 2, 1, 12'h555, 0);
    add(0, 0, 0, 0, 1, 8'hA3,   0, 1, 1, 3, 1, 12'hAAA, 0);
    add(0, 0, 0, 0, 1, 8'hFF,   0, 1, 0, 0, 1, 12'hFFF, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 0, 0, 0, 12'h000, 1);
    add(0, 0, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    // B: RGB332 frame, go during RUN and DONE ignored
    add(0, 1, 1, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   1, 1, 0, 0, 0, 12'h000, 0);
    add(0, 1, 0, 0, 1, 8'h00,   0, 1, 1, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'hE0,   0, 1, 1, 1, 1, 12'hF00, 0);
    add(0, 0, 0, 0, 1, 8'h1C,   0, 1, 1, 2, 1, 12'h0F0, 0);
    add(0, 0, 0, 0, 1, 8'h03,   0, 1, 1, 3, 1, 12'h00F, 0);
    add(0, 0, 0, 0, 1, 8'h6D,   0, 1, 0, 0, 1, 12'h665, 0);
    add(0, 1, 0, 0, 1, 8'h00,   0, 1, 0, 0, 0, 12'h000, 1);
    add(0, 0, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    // C: grant low for 3 cycles after address 1
    add(0, 1, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   1, 1, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 1, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h10,   0, 1, 1, 1, 1, 12'h111, 0);
    add(0, 0, 0, 0, 0, 8'h20,   0, 1, 0, 2, 1, 12'h222, 0);
    add(0, 0, 0, 0, 0, 8'hEE,   0, 1, 0, 2, 0, 12'h000, 0);
    add(0, 0, 0, 0, 0, 8'hEE,   0, 1, 0, 2, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'hEE,   0, 1, 1, 2, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h30,   0, 1, 1, 3, 1, 12'h333, 0);
    add(0, 0, 0, 0, 1, 8'h40,   0, 1, 0, 0, 1, 12'h444, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 0, 0, 0, 12'h000, 1);
    add(0, 0, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    // D: abort on second RUN cycle, abort in IDLE, go beats abort, abort in DONE
    add(0, 1, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   1, 1, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 1, 0, 0, 12'h000, 0);
    add(0, 0, 0, 1, 1, 8'hAA,   0, 1, 1, 1, 1, 12'hAAA, 0);
    add(0, 0, 0, 1, 1, 8'hBB,   0, 0, 0, 0, 0, 12'h000, 0);
    add(0, 1, 0, 1, 1, 8'hBB,   0, 0, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   1, 1, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 1, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h12,   0, 1, 1, 1, 1, 12'h111, 0);
    add(0, 0, 0, 0, 1, 8'h34,   0, 1, 1, 2, 1, 12'h333, 0);
    add(0, 0, 0, 0, 1, 8'h56,   0, 1, 1, 3, 1, 12'h555, 0);
    add(0, 0, 0, 0, 1, 8'h78,   0, 1, 0, 0, 1, 12'h777, 0);
    add(0, 0, 0, 1, 1, 8'h00,   0, 1, 0, 0, 0, 12'h000, 1);
    add(0, 0, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    // E: reset mid-frame (with go also high), then go on first free cycle
    add(0, 1, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   1, 1, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 1, 0, 0, 12'h000, 0);
    add(1, 1, 0, 1, 1, 8'h11,   0, 1, 1, 1, 1, 12'h111, 0);
    add(0, 1, 0, 0, 1, 8'h99,   0, 0, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   1, 1, 0, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 1, 0, 0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 8'h22,   0, 1, 1, 1, 1, 12'h222, 0);
    add(0, 0, 0, 0, 1, 8'h33,   0, 1, 1, 2, 1, 12'h333, 0);
    add(0, 0, 0, 0, 1, 8'h44,   0, 1, 1, 3, 1, 12'h444, 0);
    add(0, 0, 0, 0, 1, 8'h55,   0, 1, 0, 0, 1, 12'h555, 0);
    add(0, 0, 0, 0, 1, 8'h00,   0, 1, 0, 0, 0, 12'h000, 1);
    add(0, 0, 0, 0, 1, 8'h00,   0, 0, 0, 0, 0, 12'h000, 0);

    smem[0] = 8'h0F; smem[1] = 8'h3C; smem[2] = 8'h96; smem[3] = 8'hE1;
    sexp[0] = 12'h000; sexp[1] = 12'h333; sexp[2] = 12'h999; sexp[3] = 12'hEEE;

    rst = 1'b1; go = 1'b0; mode = 1'b0; abort = 1'b0; mem_gnt = 1'b0; rd_data = 8'h00;
    repeat (2) @(negedge clk);

    // Each vector describes one cycle: inputs applied after the falling edge,
    // outputs compared before the next rising edge.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].r; go = vecs[i].g; mode = vecs[i].m;
      abort = vecs[i].a; mem_gnt = vecs[i].n; rd_data = vecs[i].d;
      #1;
      checks++;
      if ({start, busy, rd_en, rd_addr, we, wdata, done} !==
          {vecs[i].s, vecs[i].b, vecs[i].e, vecs[i].ad, vecs[i].w, vecs[i].wd, vecs[i].dn}) begin
        errors++;
        $display("FAIL vec%0d: got start=%b busy=%b rd_en=%b addr=%0d we=%b wdata=%h done=%b want start=%b busy=%b rd_en=%b addr=%0d we=%b wdata=%h done=%b",
                 i, start, busy, rd_en, rd_addr, we, wdata, done,
                 vecs[i].s, vecs[i].b, vecs[i].e, vecs[i].ad, vecs[i].w, vecs[i].wd, vecs[i].dn);
      end
    end

    // Alternating grant with a memory model answering one cycle after each read.
    begin
      logic       prev_en;
      logic [1:0] prev_addr;
      int         nwe, ndone, nstart, overlap, cyc;
      prev_en = 1'b0; prev_addr = '0;
      nwe = 0; ndone = 0; nstart = 0; overlap = 0; cyc = 0;
      while (ndone == 0 && cyc < 60) begin
        @(negedge clk);
        rst = 1'b0; abort = 1'b0; mode = 1'b0;
        go = (cyc == 0);
        mem_gnt = cyc[0];
        rd_data = prev_en ? smem[prev_addr] : 8'h00;
        #1;
        if (int'(start) + int'(we) + int'(done) > 1) overlap++;
        if (start) nstart++;
        if (done) ndone++;
        if (we) begin
          if (nwe < 4) check($sformatf("stall_px%0d", nwe), {20'd0, wdata}, {20'd0, sexp[nwe]});
          nwe++;
        end
        prev_en = rd_en; prev_addr = rd_addr;
        cyc++;
      end
      check("stall_done_seen", ndone, 1);
      check("stall_we_count", nwe, 4);
      check("stall_start_count", nstart, 1);
      check("stall_exclusive", overlap, 0);
      @(negedge clk);
      go = 1'b0; mem_gnt = 1'b0;
      #1;
      check("stall_idle_after", {busy, done, we}, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
